// File: rtl/rv_multicycle_ctrl_if.sv
// rtl/rv_multicycle_ctrl_if.sv - handshake and control-strobe bundle between the sequencer and the datapath/memories
interface rv_multicycle_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [31:0]      inst;
    logic             branch_taken;
    logic             imem_ready;
    logic             dmem_ready;
    logic             imem_req;
    logic             dmem_req;
    logic             dmem_we;
    logic             ir_we;
    logic             pc_we;
    logic             pc_sel;
    logic             reg_we;
    logic [1:0]       alu_op;
    logic [1:0]       wb_sel;
    logic             illegal;
    logic             bus_err;
    logic [CNT_W-1:0] instret;

    modport master (
        input  inst, branch_taken, imem_ready, dmem_ready,
        output imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel, reg_we,
               alu_op, wb_sel, illegal, bus_err, instret
    );

    modport slave (
        output inst, branch_taken, imem_ready, dmem_ready,
        input  imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel, reg_we,
               alu_op, wb_sel, illegal, bus_err, instret
    );
endinterface

// File: rtl/rv_multicycle_ctrl.sv
// rtl/rv_multicycle_ctrl.sv - RV32I multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer
// Traps on illegal opcodes and memory timeouts; counts retired instructions.
module rv_multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic                clk,
    input  logic                rst,
    rv_multicycle_ctrl_if.master ctl
);
    localparam int            TW      = $clog2(MEM_TIMEOUT + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(MEM_TIMEOUT - 1);

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd7
    } state_t;

    state_t           state_q, state_d;
    logic [6:0]       op_q, op_d;
    logic [TW-1:0]    tmo_q, tmo_d;
    logic             run_q;
    logic             illegal_q, illegal_d;
    logic             bus_err_q, bus_err_d;
    logic [CNT_W-1:0] instret_q;

    logic       imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel, reg_we;
    logic [1:0] alu_op, wb_sel;
    logic       opc_legal;
    logic       is_jump;

    always_comb begin
        opc_legal = 1'b0;
        case (ctl.inst[6:0])
            OP_R, OP_I, OP_LOAD, OP_STORE, OP_BR, OP_JAL, OP_JALR, OP_LUI: opc_legal = 1'b1;
            default: opc_legal = 1'b0;
        endcase
    end

    assign is_jump = (op_q == OP_JAL) || (op_q == OP_JALR);

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        tmo_d     = '0;
        illegal_d = illegal_q;
        bus_err_d = bus_err_q;
        imem_req  = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        pc_sel    = 1'b0;
        reg_we    = 1'b0;
        alu_op    = 2'b00;
        wb_sel    = 2'b00;
        case (state_q)
            // run_q holds off the first fetch until one edge after reset release
            S_FETCH: begin
                if (run_q) begin
                    imem_req = 1'b1;
                    if (ctl.imem_ready) begin
                        ir_we   = 1'b1;
                        state_d = S_DECODE;
                    end else if (tmo_q == TO_LAST) begin
                        state_d   = S_TRAP;
                        bus_err_d = 1'b1;
                    end else begin
                        tmo_d = tmo_q + 1'b1;
                    end
                end
            end
            S_DECODE: begin
                op_d = ctl.inst[6:0];
                if (opc_legal) begin
                    state_d = S_EXEC;
                end else begin
                    state_d   = S_TRAP;
                    illegal_d = 1'b1;
                end
            end
            S_EXEC: begin
                case (op_q)
                    OP_R, OP_I: alu_op = 2'b10;
                    OP_BR:      alu_op = 2'b01;
                    OP_LUI:     alu_op = 2'b11;
                    default:    alu_op = 2'b00;
                endcase
                if (op_q == OP_BR) begin
                    pc_we   = 1'b1;
                    pc_sel  = ctl.branch_taken;
                    state_d = S_FETCH;
                end else if (op_q == OP_LOAD || op_q == OP_STORE) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (op_q == OP_STORE);
                if (ctl.dmem_ready) begin
                    if (op_q == OP_STORE) begin
                        pc_we   = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (tmo_q == TO_LAST) begin
                    state_d   = S_TRAP;
                    bus_err_d = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_WB: begin
                reg_we  = 1'b1;
                wb_sel  = (op_q == OP_LOAD) ? 2'b01 : (is_jump ? 2'b10 : 2'b00);
                pc_we   = 1'b1;
                pc_sel  = is_jump;
                state_d = S_FETCH;
            end
            S_TRAP: state_d = S_TRAP;
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_FETCH;
            op_q      <= '0;
            tmo_q     <= '0;
            run_q     <= 1'b0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            tmo_q     <= tmo_d;
            run_q     <= 1'b1;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
            if (pc_we) instret_q <= instret_q + 1'b1;
        end
    end

    assign ctl.imem_req = imem_req;
    assign ctl.dmem_req = dmem_req;
    assign ctl.dmem_we  = dmem_we;
    assign ctl.ir_we    = ir_we;
    assign ctl.pc_we    = pc_we;
    assign ctl.pc_sel   = pc_sel;
    assign ctl.reg_we   = reg_we;
    assign ctl.alu_op   = alu_op;
    assign ctl.wb_sel   = wb_sel;
    assign ctl.illegal  = illegal_q;
    assign ctl.bus_err  = bus_err_q;
    assign ctl.instret  = instret_q;
endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// tb/tb_rv_multicycle_ctrl.sv - randomized trace-model bench for rv_multicycle_ctrl
module tb_rv_multicycle_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic rst2;

    rv_multicycle_ctrl_if #(.CNT_W(32)) bus ();
    rv_multicycle_ctrl_if #(.CNT_W(32)) bus2 ();

    rv_multicycle_ctrl #(.MEM_TIMEOUT(255), .CNT_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .ctl (bus.master)
    );

    rv_multicycle_ctrl #(.MEM_TIMEOUT(4), .CNT_W(32)) dut_to (
        .clk (clk),
        .rst (rst2),
        .ctl (bus2.master)
    );

    // {imem_req,dmem_req,dmem_we,ir_we,pc_we,pc_sel,reg_we,alu_op,wb_sel,illegal,bus_err}
    logic [12:0] obs;
    assign obs = {bus.imem_req, bus.dmem_req, bus.dmem_we, bus.ir_we, bus.pc_we, bus.pc_sel,
                  bus.reg_we, bus.alu_op, bus.wb_sel, bus.illegal, bus.bus_err};

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_instret;

    typedef struct {
        logic        ir;
        logic        dr;
        logic        bt;
        logic [12:0] exp;
    } cyc_t;
    cyc_t q[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [12:0] ev(input logic ireq, input logic dreq, input logic dwe,
                                       input logic irwe, input logic pcwe, input logic pcsel,
                                       input logic regwe, input logic [1:0] alu, input logic [1:0] wb);
        return {ireq, dreq, dwe, irwe, pcwe, pcsel, regwe, alu, wb, 2'b00};
    endfunction

    task automatic push(input logic ir, input logic dr, input logic bt, input logic [12:0] e);
        cyc_t c;
        c.ir = ir; c.dr = dr; c.bt = bt; c.exp = e;
        q.push_back(c);
    endtask

    // Expected per-cycle trace of one instruction, derived from its class and the chosen waits
    task automatic run_inst(input string nm, input logic [31:0] iw, input int wi, input int wd, input logic bt);
        logic [6:0] opc;
        logic       is_ld, is_st, is_br, is_j, is_alu, is_lui;
        logic [1:0] alu;
        int         pcw;
        opc    = iw[6:0];
        is_ld  = (opc == 7'b0000011);
        is_st  = (opc == 7'b0100011);
        is_br  = (opc == 7'b1100011);
        is_j   = (opc == 7'b1101111) || (opc == 7'b1100111);
        is_alu = (opc == 7'b0110011) || (opc == 7'b0010011);
        is_lui = (opc == 7'b0110111);
        alu    = is_alu ? 2'b10 : (is_br ? 2'b01 : (is_lui ? 2'b11 : 2'b00));
        q.delete();
        for (int i = 0; i < wi; i++) push(1'b0, rb(), rb(), ev(1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00));
        push(1'b1, rb(), rb(), ev(1, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00));
        push(rb(), rb(), rb(), 13'd0);
        if (is_br) push(rb(), rb(), bt, ev(0, 0, 0, 0, 1, bt, 0, alu, 2'b00));
        else       push(rb(), rb(), rb(), ev(0, 0, 0, 0, 0, 0, 0, alu, 2'b00));
        if (is_ld || is_st) begin
            for (int i = 0; i < wd; i++) push(rb(), 1'b0, rb(), ev(0, 1, is_st, 0, 0, 0, 0, 2'b00, 2'b00));
            push(rb(), 1'b1, rb(), ev(0, 1, is_st, 0, is_st, 0, 0, 2'b00, 2'b00));
        end
        if (!is_br && !is_st)
            push(rb(), rb(), rb(), ev(0, 0, 0, 0, 1, is_j, 1, 2'b00, is_ld ? 2'b01 : (is_j ? 2'b10 : 2'b00)));
        bus.inst = iw;
        pcw = 0;
        foreach (q[c]) begin
            bus.imem_ready   = q[c].ir;
            bus.dmem_ready   = q[c].dr;
            bus.branch_taken = q[c].bt;
            @(negedge clk);
            chk($sformatf("%s.c%0d", nm, c), 64'(obs), 64'(q[c].exp));
            pcw += int'(bus.pc_we);
            @(posedge clk);
            #1;
        end
        exp_instret = exp_instret + 1;
        chk({nm, ".instret"}, 64'(bus.instret), 64'(exp_instret));
        chk({nm, ".pc_we_pulses"}, 64'(pcw), 64'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0]  opcs [8];
        logic [31:0] r;
        opcs = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                 7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111};
        rst = 1'b0; rst2 = 1'b0;
        bus.inst = '0;  bus.branch_taken = 1'b0;  bus.imem_ready = 1'b0;  bus.dmem_ready = 1'b0;
        bus2.inst = '0; bus2.branch_taken = 1'b0; bus2.imem_ready = 1'b0; bus2.dmem_ready = 1'b0;
        exp_instret = '0;

        @(posedge clk); #1;
        bus.imem_ready = 1'b1; bus.dmem_ready = 1'b1;
        #1;
        chk("rst.outs", 64'(obs), 64'd0);
        chk("rst.instret", 64'(bus.instret), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("idle.outs", 64'(obs), 64'd0);
        @(posedge clk); #1;

        run_inst("add", 32'h002081B3, 0, 0, 1'b0);
        run_inst("lw_w3", 32'h0000A103, 0, 3, 1'b0);
        run_inst("beq_t", 32'h00208063, 0, 0, 1'b1);
        run_inst("beq_nt", 32'h00208063, 0, 0, 1'b0);
        for (int n = 0; n < 150; n++) begin
            r = $urandom();
            run_inst($sformatf("rnd%0d", n), {r[31:7], opcs[$urandom_range(0, 7)]},
                     $urandom_range(0, 3), $urandom_range(0, 3), rb());
        end

        // SW: reset lands mid-MEM, between clock edges
        bus.inst = 32'h0020A023;
        bus.imem_ready = 1'b1; @(posedge clk); #1;
        bus.imem_ready = 1'b0; @(posedge clk); #1;
        @(posedge clk); #1;
        bus.dmem_ready = 1'b0;
        @(negedge clk);
        chk("sw.mem", 64'(obs), 64'(ev(0, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00)));
        #2 rst = 1'b0;
        #1;
        chk("sw.rst.dmem_req", 64'(bus.dmem_req), 64'd0);
        chk("sw.rst.instret", 64'(bus.instret), 64'd0);
        chk("sw.rst.outs", 64'(obs), 64'd0);
        exp_instret = '0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("sw.rel.imem_req", 64'(bus.imem_req), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("sw.rel.fetch", 64'(obs), 64'(ev(1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00)));
        @(posedge clk); #1;
        run_inst("add2", 32'h002081B3, 1, 0, 1'b0);

        // Illegal opcode lands in TRAP and stays quiet
        bus.inst = 32'h0000007F;
        bus.imem_ready = 1'b1;
        @(negedge clk);
        chk("ill.fetch", 64'(obs), 64'(ev(1, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00)));
        @(posedge clk); #1;
        @(negedge clk);
        chk("ill.decode", 64'(obs), 64'd0);
        @(posedge clk); #1;
        for (int i = 0; i < 20; i++) begin
            bus.imem_ready = rb(); bus.dmem_ready = rb(); bus.branch_taken = rb();
            @(negedge clk);
            chk($sformatf("ill.trap%0d", i), 64'(obs), 64'h2);
            @(posedge clk); #1;
        end
        chk("ill.instret", 64'(bus.instret), 64'(exp_instret));

        // MEM_TIMEOUT=4: four unanswered fetch cycles trap
        rst2 = 1'b1;
        @(negedge clk);
        chk("to.idle.imem_req", 64'(bus2.imem_req), 64'd0);
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("to.fetch%0d.req", i), 64'(bus2.imem_req), 64'd1);
            chk($sformatf("to.fetch%0d.bus_err", i), 64'(bus2.bus_err), 64'd0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("to.trap.bus_err", 64'(bus2.bus_err), 64'd1);
        chk("to.trap.imem_req", 64'(bus2.imem_req), 64'd0);
        @(posedge clk); #1;

        // Ready on the fourth cycle wins; then an LW times out in MEM
        rst2 = 1'b0;
        #1;
        chk("to2.rst.bus_err", 64'(bus2.bus_err), 64'd0);
        @(posedge clk); #1;
        rst2 = 1'b1;
        bus2.inst = 32'h0000A103;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin @(posedge clk); #1; end
        bus2.imem_ready = 1'b1;
        @(negedge clk);
        chk("to2.c4.ir_we", 64'(bus2.ir_we), 64'd1);
        @(posedge clk); #1;
        bus2.imem_ready = 1'b0;
        @(negedge clk);
        chk("to2.decode.bus_err", 64'(bus2.bus_err), 64'd0);
        chk("to2.decode.imem_req", 64'(bus2.imem_req), 64'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("to2.mem%0d.dmem_req", i), 64'(bus2.dmem_req), 64'd1);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("to2.mem.bus_err", 64'(bus2.bus_err), 64'd1);
        chk("to2.mem.dmem_req", 64'(bus2.dmem_req), 64'd0);
        chk("to2.instret", 64'(bus2.instret), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
